// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one valid/ready request at a time to a combinational 8-bit ALU and
// returns the result with zero/error flags and the request tag over a second valid/ready handshake.
// Optional feature macro ALU_ISSUE_FWD_EN: keeps the last returned result and substitutes it for
// operand 1 when req_fwd_a is set. Without the macro, req_fwd_a is accepted but ignored.
module alu_issue_ctrl #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_s_or_c,
    input  logic             req_shift_dir,
    input  logic [3:0]       req_op,
    input  logic [7:0]       req_a,
    input  logic [7:0]       req_b,
    input  logic             req_fwd_a,
    input  logic [TAG_W-1:0] req_tag,
    output logic [7:0]       alu_in1,
    output logic [7:0]       alu_in2,
    output logic [4:0]       alu_operation,
    input  logic [7:0]       alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [CNT_W-1:0] op_count
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [TAG_W-1:0] tag_q;
    logic             accept;
    logic             handshake;
    logic             code_err;
    logic [4:0]       op_code;
    logic [7:0]       opnd1;
    logic [7:0]       result;

    assign accept    = req_valid && req_ready;
    assign handshake = rsp_valid && rsp_ready;
    assign rsp_valid = (state == RESP);
    assign op_code   = req_s_or_c ? {4'b1000, req_shift_dir} : {1'b0, req_op};
    assign code_err  = !alu_operation[4] && (alu_operation[3:0] > 4'd5);
    assign result    = code_err ? 8'hFF : alu_out;

`ifdef ALU_ISSUE_FWD_EN
    logic [7:0] last_result;

    assign opnd1 = req_fwd_a ? last_result : req_a;

    // Remember every result the consumer takes so the next request can chain on it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_result <= '0;
        else if (handshake)
            last_result <= rsp_data;
    end
`else
    logic unused_fwd;

    assign unused_fwd = req_fwd_a;
    assign opnd1      = req_a;
`endif

    // Accept -> one ALU evaluation cycle -> hold the response until it is taken
    always_comb
        state_nxt = (state == IDLE) ? (accept ? EXEC : IDLE) :
                    (state == EXEC) ? RESP :
                    (state == RESP && !handshake) ? RESP : IDLE;

    // State and ready; ready is registered so it stays low throughout reset and rises one edge later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b0;
        end else begin
            state     <= state_nxt;
            req_ready <= (state_nxt == IDLE);
        end
    end

    // ALU operands and opcode change only on accept so the ALU sees a stable request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_in1       <= '0;
            alu_in2       <= '0;
            alu_operation <= '0;
            tag_q         <= '0;
        end else if (accept) begin
            alu_in1       <= opnd1;
            alu_in2       <= req_b;
            alu_operation <= op_code;
            tag_q         <= req_tag;
        end
    end

    // Capture the ALU result in the evaluation cycle; held unchanged while backpressured
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_zero <= 1'b0;
            rsp_err  <= 1'b0;
            rsp_tag  <= '0;
        end else if (state == EXEC) begin
            rsp_data <= result;
            rsp_zero <= (result == 8'h00);
            rsp_err  <= code_err;
            rsp_tag  <= tag_q;
        end
    end

    // Count completed response handshakes, wrapping naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            op_count <= '0;
        else if (handshake)
            op_count <= op_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and randomized checks of alu_issue_ctrl against a behavioural model.
module tb_alu_issue_ctrl;
    localparam int TAG_W = 4;
    localparam int CNT_W = 16;

    logic             clk = 0;
    logic             rst_n = 0;
    logic             req_valid = 0;
    logic             req_ready;
    logic             req_s_or_c = 0;
    logic             req_shift_dir = 0;
    logic [3:0]       req_op = 0;
    logic [7:0]       req_a = 0;
    logic [7:0]       req_b = 0;
    logic             req_fwd_a = 0;
    logic [TAG_W-1:0] req_tag = 0;
    logic [7:0]       alu_in1;
    logic [7:0]       alu_in2;
    logic [4:0]       alu_operation;
    logic [7:0]       alu_out;
    logic             rsp_valid;
    logic             rsp_ready = 0;
    logic [7:0]       rsp_data;
    logic             rsp_zero;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;
    logic [CNT_W-1:0] op_count;

    int         checks = 0;
    int         errors = 0;
    int         exp_count = 0;
    logic [7:0] last = 0;

    alu_issue_ctrl #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_s_or_c(req_s_or_c), .req_shift_dir(req_shift_dir), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_fwd_a(req_fwd_a), .req_tag(req_tag),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_operation(alu_operation), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err), .rsp_tag(rsp_tag), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Stand-in combinational ALU; unsupported codes return a non-FF value
    always_comb begin
        case (alu_operation)
            5'd0:    alu_out = alu_in1 & alu_in2;
            5'd1:    alu_out = alu_in1 | alu_in2;
            5'd2:    alu_out = alu_in1 ^ alu_in2;
            5'd3:    alu_out = ~alu_in1;
            5'd4:    alu_out = alu_in1 + alu_in2;
            5'd5:    alu_out = alu_in1 - alu_in2;
            5'd16:   alu_out = alu_in1 << alu_in2;
            5'd17:   alu_out = alu_in1 >> alu_in2;
            default: alu_out = 8'h5A;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_result(input logic s, input logic dir, input logic [3:0] op,
                                              input int a, input int b);
        if (s)
            return (b >= 8) ? 8'h00 : dir ? 8'(a / (1 << b)) : 8'((a * (1 << b)) % 256);
        case (op)
            4'd0:    return 8'(a & b);
            4'd1:    return 8'(a | b);
            4'd2:    return 8'(a ^ b);
            4'd3:    return 8'(255 - a);
            4'd4:    return 8'((a + b) % 256);
            4'd5:    return 8'((a - b + 256) % 256);
            default: return 8'hFF;
        endcase
    endfunction

    task automatic issue(input logic s, input logic dir, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] tag, input logic fwd, input int stall);
        logic [7:0] a_eff;
        logic [7:0] exp_d;
        logic [4:0] exp_code;
        logic       exp_err;
        int         n;
`ifdef ALU_ISSUE_FWD_EN
        a_eff = fwd ? last : a;
`else
        a_eff = a;
`endif
        exp_d    = ref_result(s, dir, op, int'(a_eff), int'(b));
        exp_code = s ? 5'(16 + int'(dir)) : 5'(op);
        exp_err  = !s && (op >= 4'd6);
        @(negedge clk);
        req_valid = 1; req_s_or_c = s; req_shift_dir = dir; req_op = op;
        req_a = a; req_b = b; req_tag = tag; req_fwd_a = fwd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) check("req_ready_timeout", 32'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 0;
        check("alu_operation", 32'(alu_operation), 32'(exp_code));
        check("alu_in1", 32'(alu_in1), 32'(a_eff));
        check("alu_in2", 32'(alu_in2), 32'(b));
        check("rsp_valid_exec", 32'(rsp_valid), 0);
        check("req_ready_exec", 32'(req_ready), 0);
        @(posedge clk); #1;
        check("rsp_valid", 32'(rsp_valid), 1);
        check("rsp_data", 32'(rsp_data), 32'(exp_d));
        check("rsp_zero", 32'(rsp_zero), 32'(exp_d == 8'h00));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        check("rsp_tag", 32'(rsp_tag), 32'(tag));
        repeat (stall) begin
            req_valid = 1; req_a = 8'($urandom); req_op = 4'($urandom); req_s_or_c = 1'($urandom);
            @(posedge clk); #1;
            check("hold_valid", 32'(rsp_valid), 1);
            check("hold_data", 32'(rsp_data), 32'(exp_d));
            check("hold_zero", 32'(rsp_zero), 32'(exp_d == 8'h00));
            check("hold_err", 32'(rsp_err), 32'(exp_err));
            check("hold_tag", 32'(rsp_tag), 32'(tag));
            check("hold_req_ready", 32'(req_ready), 0);
            check("hold_alu_in1", 32'(alu_in1), 32'(a_eff));
            check("hold_alu_op", 32'(alu_operation), 32'(exp_code));
        end
        req_valid = 0;
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        exp_count++;
        last = exp_d;
        check("rsp_valid_done", 32'(rsp_valid), 0);
        check("op_count", 32'(op_count), 32'(16'(exp_count)));
        check("req_ready_done", 32'(req_ready), 1);
    endtask

    initial begin
        #12;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_alu_in1", 32'(alu_in1), 0);
        check("rst_alu_op", 32'(alu_operation), 0);
        check("rst_op_count", 32'(op_count), 0);
        @(negedge clk);
        rst_n = 1;
        #1 check("ready_after_rst", 32'(req_ready), 0);
        @(posedge clk); #1;
        check("ready_first_edge", 32'(req_ready), 1);
        issue(0, 0, 4'h4, 8'h7F, 8'h01, 4'h1, 0, 0);
        issue(0, 0, 4'h5, 8'h05, 8'h05, 4'h2, 0, 0);
        issue(0, 0, 4'h4, 8'hFF, 8'h02, 4'h3, 0, 0);
        issue(1, 0, 4'h0, 8'h81, 8'h01, 4'h4, 0, 0);
        issue(1, 1, 4'h0, 8'h81, 8'h01, 4'h5, 0, 0);
        issue(1, 0, 4'h0, 8'h81, 8'h08, 4'h6, 0, 0);
        issue(0, 0, 4'h6, 8'h12, 8'h34, 4'hA, 0, 0);
        issue(0, 0, 4'hF, 8'h00, 8'h00, 4'hB, 0, 0);
        issue(0, 0, 4'h2, 8'h3C, 8'h0F, 4'h7, 0, 5);
        issue(0, 0, 4'h4, 8'h10, 8'h01, 4'h8, 0, 0);
        issue(0, 0, 4'h4, 8'h33, 8'h01, 4'h9, 1, 0);
        // Reset while the accepted request is in EXEC
        @(negedge clk);
        req_valid = 1; req_s_or_c = 0; req_op = 4'h4; req_a = 8'h10; req_b = 8'h01; req_fwd_a = 0;
        @(posedge clk); #1;
        req_valid = 0;
        check("mid_alu_in1", 32'(alu_in1), 32'h10);
        #2 rst_n = 0;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 0);
        check("mid_rst_ready", 32'(req_ready), 0);
        check("mid_rst_in1", 32'(alu_in1), 0);
        check("mid_rst_in2", 32'(alu_in2), 0);
        check("mid_rst_op", 32'(alu_operation), 0);
        check("mid_rst_count", 32'(op_count), 0);
        check("mid_rst_data", 32'(rsp_data), 0);
        check("mid_rst_tag", 32'(rsp_tag), 0);
        exp_count = 0;
        last = 0;
        @(negedge clk);
        @(negedge clk);
        check("rst_no_valid", 32'(rsp_valid), 0);
        rst_n = 1;
        @(posedge clk); #1;
        check("rst_no_valid2", 32'(rsp_valid), 0);
        check("ready_after_mid_rst", 32'(req_ready), 1);
        issue(0, 0, 4'h4, 8'h77, 8'h05, 4'hC, 1, 0);
        for (int i = 0; i < 60; i++) begin
            logic s;
            s = 1'($urandom);
            issue(s, 1'($urandom), 4'($urandom), 8'($urandom),
                  s ? 8'($urandom_range(0, 10)) : 8'($urandom),
                  4'($urandom), 1'($urandom), $urandom_range(0, 3));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
